rom_byte_writer: RTL

ROM_BYTE_WRITER -- requirements
Module: rom_byte_writer

---
 rtl/rom_byte_writer.sv | 105 ++++++++++
 1 files changed

// File: rtl/rom_byte_writer.sv
// Serialises 32-bit bridge writes into a byte stream for a ROM loader.
// A small word FIFO absorbs bursts while the loader applies backpressure.
module rom_byte_writer #(
   parameter int FIFO_DEPTH    = 4,
   parameter int ADDR_WIDTH    = 20,
   parameter bit ENDIAN_LITTLE = 1'b0
) (
   input  logic                  clk_74a,
   input  logic                  reset_n,
   input  logic                  bridge_wr,
   input  logic [31:0]           bridge_addr,
   input  logic [31:0]           bridge_wr_data,
   output logic                  rom_wr,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic [7:0]            rom_data,
   input  logic                  rom_ready,
   output logic                  idle,
   output logic                  overflow,
   output logic [31:0]           byte_count
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int HW = ADDR_WIDTH - 2;

   logic [HW-1:0] mem_addr [FIFO_DEPTH];
   logic [31:0]   mem_data [FIFO_DEPTH];

   logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
   logic [CW-1:0] count, count_next;
   logic [1:0]    idx, idx_next;
   logic          armed;
   logic          xfer, pop, push, full, drop;
   logic [HW-1:0] head_addr_next;
   logic [31:0]   head_data_next;

   function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] k);
      if (ENDIAN_LITTLE)
         return word[{k, 3'b000} +: 8];
      else
         return word[{~k, 3'b000} +: 8];
   endfunction

   always_comb begin
      xfer        = rom_wr & rom_ready;
      pop         = xfer & (idx == 2'd3);
      full        = (count == CW'(FIFO_DEPTH));
      push        = armed & bridge_wr & (~full | pop);
      drop        = armed & bridge_wr & full & ~pop;
      count_next  = count + CW'(push) - CW'(pop);
      idx_next    = xfer ? idx + 2'd1 : idx;
      rd_ptr_next = pop ? rd_ptr + PW'(1) : rd_ptr;
      wr_ptr_next = push ? wr_ptr + PW'(1) : wr_ptr;
      // A word written this cycle can become the head immediately; bypass the array.
      if (push && (wr_ptr == rd_ptr_next)) begin
         head_addr_next = bridge_addr[ADDR_WIDTH-1:2];
         head_data_next = bridge_wr_data;
      end else begin
         head_addr_next = mem_addr[rd_ptr_next];
         head_data_next = mem_data[rd_ptr_next];
      end
   end

   always_ff @(posedge clk_74a) begin
      if (push) begin
         mem_addr[wr_ptr] <= bridge_addr[ADDR_WIDTH-1:2];
         mem_data[wr_ptr] <= bridge_wr_data;
      end
   end

   // Outputs are registered from next-state values so a fresh word shows one cycle after the write.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         idx        <= '0;
         armed      <= 1'b0;
         rom_wr     <= 1'b0;
         rom_addr   <= '0;
         rom_data   <= '0;
         idle       <= 1'b1;
         overflow   <= 1'b0;
         byte_count <= '0;
      end else begin
         rd_ptr <= rd_ptr_next;
         wr_ptr <= wr_ptr_next;
         count  <= count_next;
         idx    <= idx_next;
         armed  <= 1'b1;
         rom_wr <= (count_next != '0);
         idle   <= (count_next == '0);
         if (count_next == '0) begin
            rom_addr <= '0;
            rom_data <= '0;
         end else begin
            rom_addr <= {head_addr_next, idx_next};
            rom_data <= select_byte(head_data_next, idx_next);
         end
         if (drop)
            overflow <= 1'b1;
         if (xfer)
            byte_count <= byte_count + 32'd1;
      end
   end
endmodule
